tmr_voter_pipe: RTL and testbench
=================================

Name: tmr_voter_pipe

Overview:
Parametrised, registered triple-copy majority voter with odd-copy classification, the clocked successor of our 3-input agreement classifier. Each valid cycle it takes three WIDTH-bit copies of a word and outputs their bitwise majority. It also outputs a 2-bit code naming the copy that disagrees. Per-copy saturating disagreement counters and sticky persistent-fault flags feed the status/health logic.

Parameters:
WIDTH, 8, bit width of each copy and of out_data (>=1)
CNT_W, 8, width of each per-copy disagreement counter (>=2)
PERSIST, 4, consecutive disagreements by one copy that set its sticky fault flag (1..2^CNT_W-1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  copies valid this cycle
in_c0  input  WIDTH  copy 0
in_c1  input  WIDTH  copy 1
in_c2  input  WIDTH  copy 2
clr  input  1  synchronous clear of counters, run-lengths and fault flags
out_valid  output  1  registered in_valid
out_data  output  WIDTH  bitwise majority of the three copies
out_code  output  2  00=copy0 odd, 01=copy1 odd, 10=copy2 odd, 11=all agree
out_multi  output  1  disagreements implicate more than one copy
err_cnt0  output  CNT_W  saturating disagreement count, copy 0
err_cnt1  output  CNT_W  same, copy 1
err_cnt2  output  CNT_W  same, copy 2
fault  output  3  sticky persistent-fault flag per copy

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, except out_code=2'b11. Run-length counters 0.
- Latency is 1 cycle. Inputs sampled when in_valid=1 appear on out_* the next edge. out_valid follows in_valid.
- out_data/out_code/out_multi update only on a valid cycle and hold their value otherwise.
- Per bit i: odd_k[i]=1 when copy k differs from both other copies at bit i. At most one of odd_0/1/2 is set per bit.
- Per word: dis_k = OR over i of odd_k[i].
- out_code: 11 if no dis_k. Otherwise the index of the lowest-numbered k with dis_k=1.
- out_multi = more than one dis_k set. out_code still names the lowest k.
- out_data[i] = majority(c0[i],c1[i],c2[i]), always correct per bit, including multi cases.
- Counters: on a valid cycle with dis_k=1, err_cntk increments and saturates at 2^CNT_W-1 with no wrap.
- Run-length run_k (internal, CNT_W bits): on a valid cycle it is dis_k ? saturating run_k+1 : 0. Invalid cycles leave it unchanged.
- fault[k] sets on the edge where run_k reaches PERSIST. It is sticky until clr or reset.
- clr=1: counters, run-lengths and fault go to 0 that edge. clr wins over a simultaneous valid event, so that cycle is not counted. The datapath (out_data/out_code/out_valid) still updates normally.
- Reset asserted mid-stream: everything returns to reset values immediately. The first valid cycle after release behaves as the first ever.
- No backpressure; a valid word is accepted every cycle.

Decomposition:
- Shared package holds the code constants CODE_ODD0=2'b00, CODE_ODD1=2'b01, CODE_ODD2=2'b10, CODE_AGREE=2'b11, and the 2-bit code typedef.
- One natural sub-module, tmr_copy_stats: the per-copy counter, run-length and sticky fault logic, instantiated three times with a dis_k input.
- The combinational voter/classifier stays in the top.

Test Plan:
- Reset, then 0x5A on all copies, valid -> next cycle out_valid=1, out_data=0x5A, out_code=11, out_multi=0, counters 0.
- c0=0x5B, c1=c2=0x5A -> out_data=0x5A, out_code=00, err_cnt0=1. Then c1=0xDA, others 0x5A -> out_code=01, err_cnt1=1.
- c0=0x01, c1=0x02, c2=0x00 -> out_data=0x00, out_code=00, out_multi=1, err_cnt0 and err_cnt1 both increment.
- c2 corrupted for 4 consecutive valid cycles (PERSIST=4) -> fault=3'b100 after the 4th. An invalid gap mid-run does not reset the run. A clean valid word at 3 resets it and fault stays 0.
- CNT_W=2: 5 corruptions of copy 1 -> err_cnt1 stays 3. clr together with a corrupt word -> all counters and fault 0, while out_code for that word is still 01.
- Assert rst_n low mid-run with fault set -> fault, counters and outputs clear asynchronously, before the next edge.

Source files
------------

// File: rtl/tmr_voter_pipe_pkg.sv
// Shared types and code constants for the registered triple-copy voter.
package tmr_voter_pipe_pkg;

    typedef logic [1:0] code_t;

    localparam code_t CODE_ODD0  = 2'b00;
    localparam code_t CODE_ODD1  = 2'b01;
    localparam code_t CODE_ODD2  = 2'b10;
    localparam code_t CODE_AGREE = 2'b11;

endpackage

// File: rtl/tmr_copy_stats.sv
// Per-copy health tracking: saturating disagreement count, consecutive-disagreement
// run length and a sticky fault flag once the run reaches PERSIST.
module tmr_copy_stats
    import tmr_voter_pipe_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             dis,
    input  logic             clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);

    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;

    always_comb begin
        run_nxt = '0;
        if (dis) begin
            run_nxt = (run == CNT_MAX) ? run : run + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            run     <= '0;
            fault   <= 1'b0;
        end else if (clr) begin
            err_cnt <= '0;
            run     <= '0;
            fault   <= 1'b0;
        end else if (valid) begin
            run <= run_nxt;
            if (dis && err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (run_nxt == PERSIST_C) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_voter_pipe.sv
// Registered bitwise majority voter over three copies, with odd-copy classification
// and per-copy disagreement statistics.
module tmr_voter_pipe
    import tmr_voter_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_c0,
    input  logic [WIDTH-1:0] in_c1,
    input  logic [WIDTH-1:0] in_c2,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_code,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [2:0]       fault
);

    logic [WIDTH-1:0] odd0, odd1, odd2;
    logic [WIDTH-1:0] maj;
    logic [2:0]       dis;
    code_t            code_nxt;
    logic             multi_nxt;

    // A copy is odd at a bit when it differs from both others there.
    assign odd0 = (in_c0 ^ in_c1) & (in_c0 ^ in_c2);
    assign odd1 = (in_c1 ^ in_c0) & (in_c1 ^ in_c2);
    assign odd2 = (in_c2 ^ in_c0) & (in_c2 ^ in_c1);
    assign maj  = (in_c0 & in_c1) | (in_c0 & in_c2) | (in_c1 & in_c2);
    assign dis  = {|odd2, |odd1, |odd0};

    always_comb begin
        code_nxt  = CODE_AGREE;
        multi_nxt = 1'b0;
        if (dis[0]) begin
            code_nxt = CODE_ODD0;
        end else if (dis[1]) begin
            code_nxt = CODE_ODD1;
        end else if (dis[2]) begin
            code_nxt = CODE_ODD2;
        end
        multi_nxt = (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= CODE_AGREE;
            out_multi <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= maj;
                out_code  <= code_nxt;
                out_multi <= multi_nxt;
            end
        end
    end

    tmr_copy_stats #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_stats0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (in_valid),
        .dis     (dis[0]),
        .clr     (clr),
        .err_cnt (err_cnt0),
        .fault   (fault[0])
    );

    tmr_copy_stats #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_stats1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (in_valid),
        .dis     (dis[1]),
        .clr     (clr),
        .err_cnt (err_cnt1),
        .fault   (fault[1])
    );

    tmr_copy_stats #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_stats2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (in_valid),
        .dis     (dis[2]),
        .clr     (clr),
        .err_cnt (err_cnt2),
        .fault   (fault[2])
    );

endmodule

// File: tb/tb_tmr_voter_pipe.sv
// Directed bench for tmr_voter_pipe: a default instance and a narrow-counter instance
// share one stimulus stream.
module tb_tmr_voter_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_c0, in_c1, in_c2;
    logic       clr;

    logic       a_valid, a_multi;
    logic [7:0] a_data;
    logic [1:0] a_code;
    logic [7:0] a_cnt0, a_cnt1, a_cnt2;
    logic [2:0] a_fault;

    logic       b_valid, b_multi;
    logic [7:0] b_data;
    logic [1:0] b_code;
    logic [1:0] b_cnt0, b_cnt1, b_cnt2;
    logic [2:0] b_fault;

    int total = 0;
    int bad   = 0;

    tmr_voter_pipe #(.WIDTH(8), .CNT_W(8), .PERSIST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2), .clr(clr),
        .out_valid(a_valid), .out_data(a_data), .out_code(a_code), .out_multi(a_multi),
        .err_cnt0(a_cnt0), .err_cnt1(a_cnt1), .err_cnt2(a_cnt2), .fault(a_fault)
    );

    tmr_voter_pipe #(.WIDTH(8), .CNT_W(2), .PERSIST(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2), .clr(clr),
        .out_valid(b_valid), .out_data(b_data), .out_code(b_code), .out_multi(b_multi),
        .err_cnt0(b_cnt0), .err_cnt1(b_cnt1), .err_cnt2(b_cnt2), .fault(b_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic cl);
        in_valid = v;
        in_c0    = c0;
        in_c1    = c1;
        in_c2    = c2;
        clr      = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
        in_c0 = '0; in_c1 = '0; in_c2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_data",  a_data, 8'h00);
        chk("rst_code",  a_code, 2'b11);
        chk("rst_multi", a_multi, 0);
        chk("rst_cnt0",  a_cnt0, 0);
        chk("rst_fault", a_fault, 3'b000);
        rst_n = 1'b1;

        step(1, 8'h5A, 8'h5A, 8'h5A, 0);
        chk("agree_valid", a_valid, 1);
        chk("agree_data",  a_data, 8'h5A);
        chk("agree_code",  a_code, 2'b11);
        chk("agree_multi", a_multi, 0);
        chk("agree_cnt0",  a_cnt0, 0);

        step(1, 8'h5B, 8'h5A, 8'h5A, 0);
        chk("odd0_data",  a_data, 8'h5A);
        chk("odd0_code",  a_code, 2'b00);
        chk("odd0_cnt0",  a_cnt0, 1);
        chk("odd0_multi", a_multi, 0);

        step(1, 8'h5A, 8'hDA, 8'h5A, 0);
        chk("odd1_data", a_data, 8'h5A);
        chk("odd1_code", a_code, 2'b01);
        chk("odd1_cnt1", a_cnt1, 1);
        chk("odd1_cnt0", a_cnt0, 1);

        step(1, 8'h01, 8'h02, 8'h00, 0);
        chk("multi_data",  a_data, 8'h00);
        chk("multi_code",  a_code, 2'b00);
        chk("multi_flag",  a_multi, 1);
        chk("multi_cnt0",  a_cnt0, 2);
        chk("multi_cnt1",  a_cnt1, 2);
        chk("multi_cnt2",  a_cnt2, 0);

        // copy 2 persistently corrupt, with an invalid gap mid-run
        step(1, 8'h5A, 8'h5A, 8'h5A, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        step(0, 8'h11, 8'h22, 8'h33, 0);
        chk("gap_valid", a_valid, 0);
        chk("gap_hold_code", a_code, 2'b10);
        chk("gap_hold_data", a_data, 8'h5A);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        chk("run3_fault", a_fault, 3'b000);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        chk("run4_fault", a_fault, 3'b100);
        chk("run4_cnt2",  a_cnt2, 4);

        // clean word at run 3 resets the run
        step(1, 8'h5A, 8'h5A, 8'h5A, 1);
        chk("clr_fault", a_fault, 3'b000);
        chk("clr_cnt2",  a_cnt2, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        step(1, 8'h5A, 8'h5A, 8'h5A, 0);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        chk("brk_fault", a_fault, 3'b000);
        chk("brk_cnt2",  a_cnt2, 4);

        // saturation on the 2-bit counter instance
        step(1, 8'h5A, 8'h5A, 8'h5A, 1);
        chk("b_clr_cnt1", b_cnt1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h5A, 8'h5B, 8'h5A, 0);
        chk("b_sat_cnt1",  b_cnt1, 2'd3);
        chk("b_sat_fault", b_fault, 3'b010);
        chk("a_cnt1_5",    a_cnt1, 5);
        chk("a_fault_run", a_fault, 3'b010);
        step(1, 8'h5A, 8'h5B, 8'h5A, 1);
        chk("clrw_b_cnt1",  b_cnt1, 0);
        chk("clrw_b_fault", b_fault, 3'b000);
        chk("clrw_b_code",  b_code, 2'b01);
        chk("clrw_a_cnt1",  a_cnt1, 0);
        chk("clrw_a_fault", a_fault, 3'b000);
        chk("clrw_a_code",  a_code, 2'b01);

        // asynchronous reset with a fault set
        for (int i = 0; i < 4; i++) step(1, 8'hA5, 8'h5A, 8'h5A, 0);
        chk("pre_rst_fault", a_fault, 3'b001);
        chk("pre_rst_cnt0",  a_cnt0, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_fault", a_fault, 3'b000);
        chk("arst_cnt0",  a_cnt0, 0);
        chk("arst_code",  a_code, 2'b11);
        chk("arst_valid", a_valid, 0);
        chk("arst_data",  a_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h5A, 8'h5A, 8'h5B, 0);
        chk("post_code",  a_code, 2'b10);
        chk("post_cnt2",  a_cnt2, 1);
        chk("post_cnt0",  a_cnt0, 0);
        chk("post_fault", a_fault, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
